// File: rtl/crack_ranged.sv
// RC4 key search over KEY_START, KEY_START+KEY_STRIDE, ... until a candidate decrypts the
// length-prefixed ciphertext ROM to printable text; plaintext goes to the external RAM.
module crack_ranged #(
    parameter int               KEY_W      = 24,
    parameter logic [KEY_W-1:0] KEY_START  = '0,
    parameter logic [KEY_W-1:0] KEY_STRIDE = KEY_W'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             rdy,
    input  logic             stop,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic [7:0]       ct_addr,
    input  logic [7:0]       ct_rddata,
    output logic [7:0]       pt_addr,
    output logic [7:0]       pt_wrdata,
    output logic             pt_wren
);

    typedef enum logic [3:0] {RST, IDLE, INIT, KSA, LEN_WAIT, LEN, PRGA, NEXT, DONE} state_t;

    state_t           state;
    logic [7:0]       s [256];
    logic [7:0]       i, j, k, len;
    logic [KEY_W-1:0] kshift;
    logic [7:0]       i_n, si, j_n, sj, t, pad, p;
    logic             printable, busy;
    logic [KEY_W:0]   next_key;

    // Swap and pad lookup resolve in one cycle; pad reads the post-swap S contents.
    always_comb begin
        i_n       = (state == PRGA) ? i + 8'd1 : i;
        si        = s[i_n];
        j_n       = (state == PRGA) ? j + si : j + si + kshift[KEY_W-1 -: 8];
        sj        = s[j_n];
        t         = si + sj;
        pad       = (t == i_n) ? sj : (t == j_n) ? si : s[t];
        p         = ct_rddata ^ pad;
        printable = (p >= 8'h20) && (p <= 8'h7E);
        next_key  = {1'b0, key} + {1'b0, KEY_STRIDE};
        busy      = (state != RST) && (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (state == INIT)
            s[i] <= i;
        else if (state == KSA || state == PRGA) begin
            s[i_n] <= sj;
            s[j_n] <= si;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RST;
            rdy       <= 1'b0;
            key       <= '0;
            key_valid <= 1'b0;
            ct_addr   <= '0;
            pt_addr   <= '0;
            pt_wrdata <= '0;
            pt_wren   <= 1'b0;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            len       <= '0;
            kshift    <= '0;
        end else begin
            pt_wren <= 1'b0;
            if (stop && busy) begin
                state     <= IDLE;
                rdy       <= 1'b1;
                key_valid <= 1'b0;
            end else begin
                case (state)
                    RST: state <= IDLE;
                    IDLE: begin
                        if (rdy && en) begin
                            rdy       <= 1'b0;
                            key       <= KEY_START;
                            key_valid <= 1'b0;
                            i         <= '0;
                            state     <= INIT;
                        end else begin
                            rdy <= 1'b1;
                        end
                    end
                    INIT: begin
                        i <= i + 8'd1;
                        if (i == 8'hFF) begin
                            j      <= '0;
                            kshift <= key;
                            state  <= KSA;
                        end
                    end
                    KSA: begin
                        // Rotating the key walks key[0], key[1], ... without a modulo counter
                        i      <= i + 8'd1;
                        j      <= j_n;
                        kshift <= (kshift << 8) | (kshift >> (KEY_W - 8));
                        if (i == 8'hFF) begin
                            ct_addr <= 8'd0;
                            state   <= LEN_WAIT;
                        end
                    end
                    LEN_WAIT: begin
                        // Prefetch byte 1 so PRGA consumes one ciphertext byte per cycle
                        ct_addr <= 8'd1;
                        j       <= '0;
                        state   <= LEN;
                    end
                    LEN: begin
                        len       <= ct_rddata;
                        pt_addr   <= 8'd0;
                        pt_wrdata <= ct_rddata;
                        pt_wren   <= 1'b1;
                        ct_addr   <= 8'd2;
                        k         <= 8'd1;
                        if (ct_rddata == 8'd0) begin
                            key_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= PRGA;
                        end
                    end
                    PRGA: begin
                        i       <= i_n;
                        j       <= j_n;
                        ct_addr <= ct_addr + 8'd1;
                        if (printable) begin
                            pt_addr   <= k;
                            pt_wrdata <= p;
                            pt_wren   <= 1'b1;
                            k         <= k + 8'd1;
                            if (k == len) begin
                                key_valid <= 1'b1;
                                state     <= DONE;
                            end
                        end else begin
                            state <= NEXT;
                        end
                    end
                    NEXT: begin
                        i <= '0;
                        if (next_key[KEY_W]) begin
                            state <= DONE;
                        end else begin
                            key   <= next_key[KEY_W-1:0];
                            state <= INIT;
                        end
                    end
                    DONE: begin
                        rdy   <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= RST;
                endcase
            end
        end
    end

endmodule
